// File: rtl/lmsm_pkg.sv
// Shared definitions for the load-multiple/store-multiple sequencer:
// the controller state encoding, memory write-strobe polarity and the
// default register-file / memory geometry used by the core.
package lmsm_pkg;

   localparam int LMSM_NREG   = 8;
   localparam int LMSM_DATA_W = 16;
   localparam int LMSM_ADDR_W = 16;

   localparam logic MEM_WE_STORE = 1'b1;
   localparam logic MEM_WE_LOAD  = 1'b0;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_SCAN = 3'd1,
      S_MEM  = 3'd2,
      S_WB   = 3'd3,
      S_DONE = 3'd4
   } lmsm_state_t;

endpackage

// File: rtl/lmsm_sequencer_if.sv
// Memory request/acknowledge bus between the sequencer and memory.
//   req   : request, held until ack
//   we    : write qualifier, valid with req
//   addr  : transaction address
//   wdata : store data
//   ack   : transaction complete (rdata valid in the same cycle for loads)
//   rdata : load data
// master = sequencer side, slave = memory side.
interface lmsm_mem_if
   import lmsm_pkg::*;
#(
   parameter int DATA_W = LMSM_DATA_W,
   parameter int ADDR_W = LMSM_ADDR_W
) ();

   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              ack;
   logic [DATA_W-1:0] rdata;

   modport master (output req, we, addr, wdata, input ack, rdata);
   modport slave  (input req, we, addr, wdata, output ack, rdata);

endinterface

// File: rtl/lmsm_sequencer_prio_enc.sv
// Lowest-set-bit priority encoder.
//   req : request vector (NREG bits)
//   idx : index of the lowest set bit (0 when req is empty)
//   vld : at least one bit of req is set
module prio_enc_lsb #(
   parameter int NREG = 8,
   localparam int REG_AW = $clog2(NREG)
) (
   input  logic [NREG-1:0]   req,
   output logic [REG_AW-1:0] idx,
   output logic              vld
);

   // Scan downward so the lowest set bit is the last assignment to win.
   always_comb begin
      idx = '0;
      vld = |req;
      for (int i = NREG - 1; i >= 0; i--) begin
         if (req[i]) idx = REG_AW'(i);
      end
   end

endmodule

// File: rtl/lmsm_sequencer.sv
// Load-multiple / store-multiple sequencer. Walks the set bits of a register
// mask lowest-first and performs one memory transaction per selected
// register over a req/ack handshake, at consecutive addresses from base.
//   clk, reset                : clock, synchronous active-high reset
//   start/is_store/reg_mask/base_addr : command, sampled in IDLE only
//   busy, done, xfer_count    : status
//   mem                       : memory bus (master side)
//   rf_raddr/rf_rdata         : register-file read port (combinational)
//   rf_wen/rf_waddr/rf_wdata  : register-file write port
module lmsm_sequencer
   import lmsm_pkg::*;
#(
   parameter int NREG   = LMSM_NREG,
   parameter int DATA_W = LMSM_DATA_W,
   parameter int ADDR_W = LMSM_ADDR_W,
   localparam int REG_AW = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              is_store,
   input  logic [NREG-1:0]   reg_mask,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              busy,
   output logic              done,
   output logic [REG_AW:0]   xfer_count,
   lmsm_mem_if.master        mem,
   output logic [REG_AW-1:0] rf_raddr,
   input  logic [DATA_W-1:0] rf_rdata,
   output logic              rf_wen,
   output logic [REG_AW-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata
);

   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
   localparam logic [REG_AW:0]   CNT_ONE  = (REG_AW + 1)'(1);
   localparam logic [NREG-1:0]   BIT_ONE  = NREG'(1);

   lmsm_state_t       state_q, state_d;
   logic              is_store_q, is_store_d;
   logic [NREG-1:0]   mask_q, mask_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [REG_AW-1:0] cur_idx_q, cur_idx_d;
   logic [REG_AW:0]   xfer_count_q, xfer_count_d;
   logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

   logic [REG_AW-1:0] enc_idx;
   logic              enc_vld;
   logic [NREG-1:0]   mask_clr;

   prio_enc_lsb #(.NREG(NREG)) u_enc (
      .req (mask_q),
      .idx (enc_idx),
      .vld (enc_vld)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         is_store_q   <= 1'b0;
         mask_q       <= '0;
         addr_q       <= '0;
         cur_idx_q    <= '0;
         xfer_count_q <= '0;
         rf_wdata_q   <= '0;
      end else begin
         state_q      <= state_d;
         is_store_q   <= is_store_d;
         mask_q       <= mask_d;
         addr_q       <= addr_d;
         cur_idx_q    <= cur_idx_d;
         xfer_count_q <= xfer_count_d;
         rf_wdata_q   <= rf_wdata_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      is_store_d   = is_store_q;
      mask_d       = mask_q;
      addr_d       = addr_q;
      cur_idx_d    = cur_idx_q;
      xfer_count_d = xfer_count_q;
      rf_wdata_d   = rf_wdata_q;
      mem.req      = 1'b0;
      mem.we       = MEM_WE_LOAD;
      rf_wen       = 1'b0;
      done         = 1'b0;
      busy         = (state_q != S_IDLE);
      // Mask with the register just transferred retired.
      mask_clr     = mask_q & ~(BIT_ONE << cur_idx_q);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               is_store_d   = is_store;
               mask_d       = reg_mask;
               addr_d       = base_addr;
               xfer_count_d = '0;
               state_d      = (reg_mask == '0) ? S_DONE : S_SCAN;
            end
         end
         S_SCAN: begin
            cur_idx_d = enc_idx;
            state_d   = enc_vld ? S_MEM : S_DONE;
         end
         S_MEM: begin
            mem.req = 1'b1;
            mem.we  = is_store_q ? MEM_WE_STORE : MEM_WE_LOAD;
            if (mem.ack) begin
               if (is_store_q) begin
                  mask_d       = mask_clr;
                  addr_d       = addr_q + ADDR_ONE;
                  xfer_count_d = xfer_count_q + CNT_ONE;
                  state_d      = (mask_clr == '0) ? S_DONE : S_SCAN;
               end else begin
                  rf_wdata_d = mem.rdata;
                  state_d    = S_WB;
               end
            end
         end
         S_WB: begin
            rf_wen       = 1'b1;
            mask_d       = mask_clr;
            addr_d       = addr_q + ADDR_ONE;
            xfer_count_d = xfer_count_q + CNT_ONE;
            state_d      = (mask_clr == '0) ? S_DONE : S_SCAN;
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign mem.addr   = addr_q;
   assign mem.wdata  = rf_rdata;
   assign rf_raddr   = cur_idx_q;
   assign rf_waddr   = cur_idx_q;
   assign rf_wdata   = rf_wdata_q;
   assign xfer_count = xfer_count_q;

endmodule
